regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the 32x32 register file's single write port. Three requesters share the port: ALU write-back, load write-back, and the multicycle mul/div unit. The arbiter grants one request per cycle and registers the winning register number and data onto the write port. It also flags read-after-write hazards on both read ports so the issue logic can stall.

---
 rtl/regfile_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Write-back arbiter for the single write port of the 32x32 register file.
// Three requesters (0 = ALU, 1 = load, 2 = mul/div) compete for the port.
// One request is granted per cycle, and the winner is registered onto the port.
// Read-after-write hazards are flagged on both read ports.
//
// Configuration macro: RFARB_RR_EN
//   defined   -> round-robin arbitration starting at a 2-bit pointer
//   undefined -> fixed priority, req[0] > req[1] > req[2], no pointer
module regfile_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          i_clk,
    input  logic          i_clrn,
    input  logic [2:0]    i_req,
    input  logic [AW-1:0] i_wn0,
    input  logic [AW-1:0] i_wn1,
    input  logic [AW-1:0] i_wn2,
    input  logic [DW-1:0] i_d0,
    input  logic [DW-1:0] i_d1,
    input  logic [DW-1:0] i_d2,
    output logic [2:0]    o_gnt,
    input  logic [AW-1:0] i_rna,
    input  logic [AW-1:0] i_rnb,
    output logic          o_hz_a,
    output logic          o_hz_b,
    output logic [AW-1:0] o_rf_wn,
    output logic [DW-1:0] o_rf_data,
    output logic          o_rf_we
);

    logic [2:0]    w_gnt_raw;
    logic [2:0]    w_gnt;
    logic [AW-1:0] w_wn     [3];
    logic [DW-1:0] w_d      [3];
    logic [AW-1:0] w_wn_sel [3];
    logic [DW-1:0] w_d_sel  [3];
    logic [2:0]    w_hit_a;
    logic [2:0]    w_hit_b;
    logic [AW-1:0] w_win_wn;
    logic [DW-1:0] w_win_d;

    logic [AW-1:0] r_rf_wn;
    logic [DW-1:0] r_rf_data;
    logic          r_rf_we;

    assign w_wn[0] = i_wn0;
    assign w_wn[1] = i_wn1;
    assign w_wn[2] = i_wn2;
    assign w_d[0]  = i_d0;
    assign w_d[1]  = i_d1;
    assign w_d[2]  = i_d2;

`ifdef RFARB_RR_EN
    logic [1:0] r_ptr;

    // Round-robin: search starts at r_ptr and wraps 0 -> 1 -> 2 -> 0.
    always_comb begin
        w_gnt_raw = 3'b000;
        case (r_ptr)
            2'd1: begin
                if (i_req[1])      w_gnt_raw = 3'b010;
                else if (i_req[2]) w_gnt_raw = 3'b100;
                else if (i_req[0]) w_gnt_raw = 3'b001;
            end
            2'd2: begin
                if (i_req[2])      w_gnt_raw = 3'b100;
                else if (i_req[0]) w_gnt_raw = 3'b001;
                else if (i_req[1]) w_gnt_raw = 3'b010;
            end
            default: begin
                if (i_req[0])      w_gnt_raw = 3'b001;
                else if (i_req[1]) w_gnt_raw = 3'b010;
                else if (i_req[2]) w_gnt_raw = 3'b100;
            end
        endcase
    end

    // Pointer moves past the winner; r0 writes still count as a grant.
    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_ptr <= 2'd0;
        end else if (w_gnt[0]) begin
            r_ptr <= 2'd1;
        end else if (w_gnt[1]) begin
            r_ptr <= 2'd2;
        end else if (w_gnt[2]) begin
            r_ptr <= 2'd0;
        end
    end
`else
    // Fixed priority: lowest requester index wins.
    always_comb begin
        w_gnt_raw = 3'b000;
        if (i_req[0])      w_gnt_raw = 3'b001;
        else if (i_req[1]) w_gnt_raw = 3'b010;
        else if (i_req[2]) w_gnt_raw = 3'b100;
    end
`endif

    // No grant may be issued while reset is held.
    assign w_gnt = w_gnt_raw & {3{i_clrn}};
    assign o_gnt = w_gnt;

    // One-hot AND-OR mux of the winner, plus per-requester hazard matches.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_req
            assign w_wn_sel[gi] = w_gnt[gi] ? w_wn[gi] : '0;
            assign w_d_sel[gi]  = w_gnt[gi] ? w_d[gi]  : '0;
            assign w_hit_a[gi]  = i_req[gi] && (w_wn[gi] == i_rna);
            assign w_hit_b[gi]  = i_req[gi] && (w_wn[gi] == i_rnb);
        end
    endgenerate

    assign w_win_wn = w_wn_sel[0] | w_wn_sel[1] | w_wn_sel[2];
    assign w_win_d  = w_d_sel[0]  | w_d_sel[1]  | w_d_sel[2];

    // Write stage: register the winner; r0 targets are consumed without a write.
    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_rf_wn   <= '0;
            r_rf_data <= '0;
            r_rf_we   <= 1'b0;
        end else if (|w_gnt) begin
            r_rf_wn   <= w_win_wn;
            r_rf_data <= w_win_d;
            r_rf_we   <= (w_win_wn != '0);
        end else begin
            r_rf_we   <= 1'b0;
        end
    end

    assign o_rf_wn   = r_rf_wn;
    assign o_rf_data = r_rf_data;
    assign o_rf_we   = r_rf_we;

    // Hazard covers both pending requests and the registered write not yet in the regfile.
    assign o_hz_a = (i_rna != '0) && ((r_rf_we && (r_rf_wn == i_rna)) || (|w_hit_a));
    assign o_hz_b = (i_rnb != '0) && ((r_rf_we && (r_rf_wn == i_rnb)) || (|w_hit_b));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter, including a behavioural regfile model.
// Expectations follow RFARB_RR_EN when it is defined; otherwise fixed priority is assumed.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          clrn;
    logic [2:0]    req;
    logic [AW-1:0] wn0, wn1, wn2;
    logic [DW-1:0] d0, d1, d2;
    logic [2:0]    gnt;
    logic [AW-1:0] rna, rnb;
    logic          hz_a, hz_b;
    logic [AW-1:0] rf_wn;
    logic [DW-1:0] rf_data;
    logic          rf_we;

    logic [DW-1:0] rf [32];

    int n_checks;
    int n_fail;

    regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .i_clk     (clk),
        .i_clrn    (clrn),
        .i_req     (req),
        .i_wn0     (wn0),
        .i_wn1     (wn1),
        .i_wn2     (wn2),
        .i_d0      (d0),
        .i_d1      (d1),
        .i_d2      (d2),
        .o_gnt     (gnt),
        .i_rna     (rna),
        .i_rnb     (rnb),
        .o_hz_a    (hz_a),
        .o_hz_b    (hz_b),
        .o_rf_wn   (rf_wn),
        .o_rf_data (rf_data),
        .o_rf_we   (rf_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile model writes any enabled address (r0 included) so a stray r0 write is visible.
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
    end
    always @(posedge clk) begin
        if (rf_we) rf[rf_wn] <= rf_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clrn = 1'b0;
        req  = 3'b111;
        wn0 = 5'd1; d0 = 32'hAAAA_0001;
        wn1 = 5'd2; d1 = 32'hBBBB_0002;
        wn2 = 5'd3; d2 = 32'hCCCC_0003;
        rna = '0;   rnb = '0;

        // Reset held with all requests up
        tick(); tick(); #1;
        chk("rst_gnt",   gnt,     3'b000);
        chk("rst_we",    rf_we,   1'b0);
        chk("rst_wn",    rf_wn,   5'd0);
        chk("rst_data",  rf_data, 32'h0);

        // Release: first grant goes to requester 0 in both modes
        clrn = 1'b1; #1;
        chk("first_gnt", gnt, 3'b001);

        // Contention: each requester drops once granted
        tick(); req = 3'b110; #1;
        chk("cont_gnt1", gnt,     3'b010);
        chk("cont_we0",  rf_we,   1'b1);
        chk("cont_wn0",  rf_wn,   5'd1);
        chk("cont_d0",   rf_data, 32'hAAAA_0001);
        tick(); req = 3'b100; #1;
        chk("cont_gnt2", gnt,     3'b100);
        chk("cont_wn1",  rf_wn,   5'd2);
        chk("cont_d1",   rf_data, 32'hBBBB_0002);
        tick(); req = 3'b000; #1;
        chk("cont_idle", gnt,     3'b000);
        chk("cont_we2",  rf_we,   1'b1);
        chk("cont_wn2",  rf_wn,   5'd3);
        chk("cont_d2",   rf_data, 32'hCCCC_0003);
        tick(); #1;
        chk("idle_we",   rf_we,   1'b0);
        chk("idle_wn",   rf_wn,   5'd3);
        chk("rf_r1",     rf[1],   32'hAAAA_0001);
        chk("rf_r2",     rf[2],   32'hBBBB_0002);
        chk("rf_r3",     rf[3],   32'hCCCC_0003);

        // Requesters 0 and 2 held continuously
        wn0 = 5'd10; d0 = 32'h0000_0010;
        wn2 = 5'd11; d2 = 32'h0000_0011;
        req = 3'b101; #1;
        chk("hold_gnt0", gnt, 3'b001);
        tick(); #1;
`ifdef RFARB_RR_EN
        chk("hold_gnt1", gnt, 3'b100);
`else
        chk("hold_gnt1", gnt, 3'b001);
`endif
        tick(); #1;
        chk("hold_gnt2", gnt, 3'b001);
        tick(); req = 3'b000;
        tick(); tick();

        // Single write from the load requester
        wn1 = 5'd5; d1 = 32'hDEAD_BEEF;
        req = 3'b010; #1;
        chk("single_gnt", gnt, 3'b010);
        tick(); req = 3'b000; #1;
        chk("single_we",   rf_we,   1'b1);
        chk("single_wn",   rf_wn,   5'd5);
        chk("single_data", rf_data, 32'hDEAD_BEEF);
        tick(); #1;
        chk("rf_r5",       rf[5],   32'hDEAD_BEEF);

        // Write to r0 is granted but never enabled
        wn2 = 5'd0; d2 = 32'hFFFF_FFFF;
        rna = 5'd0; rnb = 5'd0;
        req = 3'b100; #1;
        chk("r0_gnt",  gnt,  3'b100);
        chk("r0_hz_a", hz_a, 1'b0);
        tick(); req = 3'b000; #1;
        chk("r0_we",   rf_we,   1'b0);
        chk("r0_wn",   rf_wn,   5'd0);
        chk("r0_data", rf_data, 32'hFFFF_FFFF);
        chk("r0_hz_a1", hz_a,   1'b0);
        tick(); #1;
        chk("rf_r0",   rf[0],   32'h0);

        // Hazard window: pending request, then registered write
        rna = 5'd7; rnb = 5'd7;
        wn0 = 5'd7; d0 = 32'h0000_1234;
        req = 3'b001; #1;
        chk("hz_gnt",   gnt,  3'b001);
        chk("hz_a_n",   hz_a, 1'b1);
        chk("hz_b_n",   hz_b, 1'b1);
        tick(); req = 3'b000; #1;
        chk("hz_we_n1", rf_we, 1'b1);
        chk("hz_a_n1",  hz_a,  1'b1);
        chk("hz_b_n1",  hz_b,  1'b1);
        tick(); #1;
        chk("hz_a_n2",  hz_a,  1'b0);
        chk("rf_r7",    rf[7], 32'h0000_1234);

        // Hazard then reset during the write cycle
        rnb = 5'd9;
        d0  = 32'h0000_5678;
        req = 3'b001; #1;
        chk("hz2_a_n",  hz_a, 1'b1);
        chk("hz2_b_n",  hz_b, 1'b0);
        tick(); req = 3'b000; #1;
        chk("hz2_we",   rf_we, 1'b1);
        chk("hz2_a_n1", hz_a,  1'b1);
        clrn = 1'b0; #1;
        chk("mrst_we",   rf_we, 1'b0);
        chk("mrst_wn",   rf_wn, 5'd0);
        chk("mrst_hz_a", hz_a,  1'b0);
        tick(); clrn = 1'b1; #1;
        chk("rf_r7_keep", rf[7], 32'h0000_1234);
        chk("post_we",    rf_we, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
